// File: rtl/cpu_pkg.sv
// Shared core types: store width encoding, store-queue entry and the lane
// alignment helpers that the load queue will reuse.
package cpu_pkg;
    localparam int CPU_XLEN  = 32;
    localparam int CPU_TAG_W = 4;

    typedef enum logic [1:0] {SB = 2'b00, SH = 2'b01, SW = 2'b10} store_width_e;

    typedef struct packed {
        logic                 valid;
        logic [CPU_TAG_W-1:0] rob_tag;
        store_width_e         width;
        logic [CPU_XLEN-1:0]  address;
        logic                 address_valid;
        logic [CPU_XLEN-1:0]  data;
        logic                 data_valid;
        logic [CPU_TAG_W-1:0] data_tag;
        logic                 committed;
        logic                 exc;
    } stq_entry_t;

    // Byte offset actually used: address bits below the access size are ignored.
    function automatic logic [1:0] lane_offset(store_width_e w, logic [1:0] a);
        case (w)
            SB:      return a;
            SH:      return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_byte_en(store_width_e w, logic [1:0] a);
        case (w)
            SB:      return 4'b0001 << lane_offset(w, a);
            SH:      return 4'b0011 << lane_offset(w, a);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic is_misaligned(store_width_e w, logic [1:0] a);
        case (w)
            SH:      return a[0];
            SW:      return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/store_queue_if.sv
// Data-memory write port of the store queue (valid/ready).
interface store_queue_if #(parameter int XLEN = 32);
    logic            mem_write_valid;
    logic            mem_write_ready;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_data;
    logic [3:0]      mem_byte_en;

    modport master (output mem_write_valid, mem_address, mem_data, mem_byte_en,
                    input  mem_write_ready);
    modport slave  (input  mem_write_valid, mem_address, mem_data, mem_byte_en,
                    output mem_write_ready);
endinterface

// File: rtl/stq_lane_align.sv
// Width/offset to byte strobes, lane-shifted data and word-aligned address.
module stq_lane_align
    import cpu_pkg::*;
#(parameter int XLEN = CPU_XLEN) (
    input  store_width_e    i_width,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_addr,
    output logic [XLEN-1:0] o_data,
    output logic [3:0]      o_byte_en
);
    logic [1:0] w_off;

    assign w_off     = lane_offset(i_width, i_addr[1:0]);
    assign o_addr    = {i_addr[XLEN-1:2], 2'b00};
    assign o_data    = i_data << {w_off, 3'b000};
    assign o_byte_en = lane_byte_en(i_width, i_addr[1:0]);
endmodule

// File: rtl/store_queue.sv
// Circular store queue: alloc at dispatch, AGU/CDB capture, in-order commit and
// drain, flush of uncommitted stores. Optional macro: STQ_MISALIGN_EN.
module store_queue
    import cpu_pkg::*;
#(
    parameter int XLEN      = CPU_XLEN,
    parameter int STQ_SIZE  = 8,
    parameter int TAG_WIDTH = CPU_TAG_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [TAG_WIDTH-1:0] alloc_rob_tag,
    input  logic [1:0]           alloc_width,
    input  logic                 alloc_data_ready,
    input  logic [XLEN-1:0]      alloc_data,
    input  logic [TAG_WIDTH-1:0] alloc_data_tag,
    output logic                 full,
    output logic                 empty,
    input  logic                 agu_valid,
    input  logic [TAG_WIDTH-1:0] agu_rob_tag,
    input  logic [XLEN-1:0]      agu_address,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_rob_tag,
    input  logic [XLEN-1:0]      cdb_data,
    input  logic                 commit_en,
    input  logic [TAG_WIDTH-1:0] commit_rob_tag,
    input  logic                 flush,
    store_queue_if.master        mem
`ifdef STQ_MISALIGN_EN
    ,
    output logic                 misaligned_valid,
    output logic [TAG_WIDTH-1:0] misaligned_rob_tag
`endif
);
    localparam int IW = $clog2(STQ_SIZE);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_head, r_cptr, r_tail;
    stq_entry_t    r_q [STQ_SIZE];

    logic [IW-1:0] w_head_idx, w_cptr_idx, w_tail_idx;
    logic [PW-1:0] w_count, w_cptr_nxt;
    stq_entry_t    w_head_e, w_cmt_e, w_new;
    logic          w_head_rdy, w_drain, w_commit, w_alloc;
    logic [XLEN-1:0] w_al_addr, w_al_data;
    logic [3:0]      w_al_be;

    assign w_head_idx = r_head[IW-1:0];
    assign w_cptr_idx = r_cptr[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];
    assign w_count    = r_tail - r_head;
    assign full       = (w_count == PW'(STQ_SIZE));
    assign empty      = (r_tail == r_head);
    assign w_head_e   = r_q[w_head_idx];
    assign w_cmt_e    = r_q[w_cptr_idx];

    assign w_head_rdy = w_head_e.valid && w_head_e.committed && w_head_e.address_valid
                        && w_head_e.data_valid && !w_head_e.exc;
    assign w_drain    = w_head_rdy && mem.mem_write_ready;
    assign w_commit   = commit_en && (r_cptr != r_tail) && w_cmt_e.valid
                        && (w_cmt_e.rob_tag == commit_rob_tag);
    assign w_cptr_nxt = r_cptr + PW'(w_commit);
    assign w_alloc    = alloc_en && !full && !flush;

    // New entry; producer result on the CDB this cycle is caught directly.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.rob_tag  = alloc_rob_tag;
        w_new.width    = store_width_e'(alloc_width);
        w_new.data_tag = alloc_data_tag;
        if (alloc_data_ready) begin
            w_new.data       = alloc_data;
            w_new.data_valid = 1'b1;
        end else if (cdb_valid && cdb_rob_tag == alloc_data_tag) begin
            w_new.data       = cdb_data;
            w_new.data_valid = 1'b1;
        end
    end

    stq_lane_align #(.XLEN(XLEN)) u_align (
        .i_width   (w_head_e.width),
        .i_addr    (w_head_e.address),
        .i_data    (w_head_e.data),
        .o_addr    (w_al_addr),
        .o_data    (w_al_data),
        .o_byte_en (w_al_be)
    );

    assign mem.mem_write_valid = w_head_rdy;
    assign mem.mem_address     = w_head_rdy ? w_al_addr : '0;
    assign mem.mem_data        = w_head_rdy ? w_al_data : '0;
    assign mem.mem_byte_en     = w_head_rdy ? w_al_be   : '0;

`ifdef STQ_MISALIGN_EN
    logic                 r_mis_valid;
    logic [TAG_WIDTH-1:0] r_mis_tag;
    assign misaligned_valid   = r_mis_valid;
    assign misaligned_rob_tag = r_mis_tag;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_cptr <= '0;
            r_tail <= '0;
            for (int i = 0; i < STQ_SIZE; i++) r_q[i] <= '0;
`ifdef STQ_MISALIGN_EN
            r_mis_valid <= 1'b0;
            r_mis_tag   <= '0;
`endif
        end else begin
`ifdef STQ_MISALIGN_EN
            r_mis_valid <= 1'b0;
`endif
            for (int i = 0; i < STQ_SIZE; i++) begin
                if (agu_valid && r_q[i].valid && r_q[i].rob_tag == agu_rob_tag) begin
                    r_q[i].address       <= agu_address;
                    r_q[i].address_valid <= 1'b1;
`ifdef STQ_MISALIGN_EN
                    r_q[i].exc <= is_misaligned(r_q[i].width, agu_address[1:0]);
                    if (is_misaligned(r_q[i].width, agu_address[1:0])) begin
                        r_mis_valid <= 1'b1;
                        r_mis_tag   <= agu_rob_tag;
                    end
`endif
                end
                if (cdb_valid && r_q[i].valid && !r_q[i].data_valid
                    && r_q[i].data_tag == cdb_rob_tag) begin
                    r_q[i].data       <= cdb_data;
                    r_q[i].data_valid <= 1'b1;
                end
                // Entry committed in this very cycle survives the flush.
                if (flush && r_q[i].valid && !r_q[i].committed
                    && !(w_commit && IW'(i) == w_cptr_idx))
                    r_q[i].valid <= 1'b0;
            end
            if (w_commit) r_q[w_cptr_idx].committed <= 1'b1;
            if (w_drain)  r_q[w_head_idx] <= '0;
            if (w_alloc)  r_q[w_tail_idx] <= w_new;
            r_head <= r_head + PW'(w_drain);
            r_cptr <= w_cptr_nxt;
            r_tail <= flush ? w_cptr_nxt : r_tail + PW'(w_alloc);
        end
    end

    always @(posedge clk)
        if (!reset && commit_en) assert (w_commit);
endmodule
